// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
// The alignment check is compiled in only when DATA_MEM_ALIGN_CHECK_EN is defined.
package data_mem_responder_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MASK_WORD = 32'hFFFF_FFFF;
    localparam logic [DATA_WIDTH-1:0] MASK_HALF = 32'h0000_FFFF;
    localparam logic [DATA_WIDTH-1:0] MASK_BYTE = 32'h0000_00FF;

    // Full-word access needs a word-aligned address; low half-word needs an even one.
    function automatic logic is_misaligned(input logic full_word, input logic low_half,
                                           input logic [1:0] offset);
        return (full_word && (offset != 2'b00)) || (low_half && offset[0]);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Initiator/responder bus for data_mem_responder, plus a debug view of the FSM state.
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int AddrWidth = 12
);
    // request is sampled only while the responder is IDLE and enable is high; ready is a
    // one-cycle strobe and rData/error are meaningful only in that cycle. busy covers the
    // whole access, so a request raised while busy is dropped rather than queued.
    logic                 enable;
    logic                 request;
    logic                 write;
    logic [AddrWidth-1:0] dataAddr;
    logic [DataWidth-1:0] wData;
    logic [DataWidth-1:0] wDataMask;
    logic                 ready;
    logic [DataWidth-1:0] rData;
    logic                 busy;
    logic                 error;
    state_t               dbg_state;

    modport master (
        output enable, request, write, dataAddr, wData, wDataMask,
        input  ready, rData, busy, error, dbg_state
    );

    modport slave (
        input  enable, request, write, dataAddr, wData, wDataMask,
        output ready, rData, busy, error, dbg_state
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// Word storage: one registered read port and one bit-masked write port, no reset.
module data_mem_array #(
    parameter int DataWidth = 32,
    parameter int Depth     = 1024,
    parameter int IdxWidth  = $clog2(Depth)
) (
    input  logic                 clock,
    input  logic                 re,
    input  logic [IdxWidth-1:0]  raddr,
    output logic [DataWidth-1:0] rdata,
    input  logic                 we,
    input  logic [IdxWidth-1:0]  waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [DataWidth-1:0] wmask
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clock) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: IDLE -> WAIT (Latency cycles) -> RESP -> IDLE.
// Define DATA_MEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int AddrWidth = 12,
    parameter int Latency   = 2
) (
    input logic                 clock,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int IdxWidth = AddrWidth - 2;
    localparam int Depth    = 1 << IdxWidth;
    localparam logic [CNT_WIDTH-1:0] CntLoad = CNT_WIDTH'((Latency > 0) ? Latency - 1 : 0);

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic                   write_q;
    logic [IdxWidth-1:0]    idx_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [DataWidth-1:0]   mask_q;
    logic                   accept;
    logic                   misaligned;
    logic                   mem_re;
    logic                   mem_we;
    logic [IdxWidth-1:0]    mem_raddr;
    logic [DataWidth-1:0]   mem_rdata;

    assign accept = (state == IDLE) && bus.request;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam logic [DataWidth-1:0] WordMask = '1;
    localparam logic [DataWidth-1:0] HalfMask =
        {{(DataWidth - DataWidth/2){1'b0}}, {(DataWidth/2){1'b1}}};

    logic [1:0] off_q;

    always_ff @(posedge clock) begin
        if (!reset && bus.enable && accept) begin
            off_q <= bus.dataAddr[1:0];
        end
    end

    assign misaligned = is_misaligned(mask_q == WordMask, mask_q == HalfMask, off_q);
`else
    logic unused_offset;

    assign unused_offset = ^bus.dataAddr[1:0];
    assign misaligned    = 1'b0;
`endif

    // State register; the access fields are captured only at accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.enable) begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                write_q <= bus.write;
                idx_q   <= bus.dataAddr[AddrWidth-1:2];
                wdata_q <= bus.wData;
                mask_q  <= bus.wDataMask;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.request) begin
                    if (Latency == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CntLoad;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read is launched on the edge entering RESP, so it sees the word before this store.
    always_comb begin
        mem_re        = !reset && bus.enable && (state_next == RESP) && (state != RESP);
        mem_raddr     = (state == IDLE) ? bus.dataAddr[AddrWidth-1:2] : idx_q;
        mem_we        = !reset && bus.enable && (state == RESP) && write_q && !misaligned;
        bus.ready     = (state == RESP);
        bus.busy      = (state != IDLE);
        bus.error     = (state == RESP) && misaligned;
        bus.rData     = ((state == RESP) && !misaligned) ? mem_rdata : '0;
        bus.dbg_state = state;
    end

    data_mem_array #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .IdxWidth  (IdxWidth)
    ) u_array (
        .clock (clock),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .wmask (mask_q)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: Latency=2 instance for the main sequence and a
// Latency=0 instance for back-to-back timing.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int LAT   = 2;
    localparam int WORDS = 1 << (AW - 2);

    // clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    data_mem_responder_if #(.DataWidth(DW), .AddrWidth(AW)) bus  ();
    data_mem_responder_if #(.DataWidth(DW), .AddrWidth(AW)) bus0 ();

    data_mem_responder #(.DataWidth(DW), .AddrWidth(AW), .Latency(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    data_mem_responder #(.DataWidth(DW), .AddrWidth(AW), .Latency(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    // scoreboard
    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] model [WORDS];
    bit            known [WORDS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit misaligned_f(input logic [DW-1:0] mask, input logic [AW-1:0] addr);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        return ((mask == MASK_WORD) && (addr[1:0] != 2'b00)) ||
               ((mask == MASK_HALF) && addr[0]);
`else
        return (mask == '0) && (addr == '0) && 1'b0;
`endif
    endfunction

    // driver: one access on the Latency=2 instance
    task automatic access(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask, input int stall_at, input int stall_len,
                          input int abort_at);
        int            idx;
        bit            mis;
        bit            rd_known;
        bit            got;
        int            n;
        logic [DW-1:0] exp_rd;
        logic [DW:0]   exp;
        idx      = int'(addr[AW-1:2]);
        mis      = misaligned_f(mask, addr);
        rd_known = mis || known[idx];
        exp_rd   = mis ? '0 : model[idx];
        if (abort_at == 0) exp_q.push_back({mis, exp_rd});

        @(negedge clock);
        bus.request   = 1'b1;
        bus.write     = wr;
        bus.dataAddr  = addr;
        bus.wData     = data;
        bus.wDataMask = mask;
        @(posedge clock);
        @(negedge clock);
        bus.request = 1'b0;
        n   = 1;
        got = 1'b0;
        while (n <= 40) begin
            if (n == 1) begin
                check("busy_in_wait", 64'(bus.busy), 64'(1));
                check("state_wait", 64'(bus.dbg_state), 64'(WAIT));
            end
            if (n == abort_at) begin
                reset = 1'b1;
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
                check("abort_busy", 64'(bus.busy), 64'(0));
                check("abort_ready", 64'(bus.ready), 64'(0));
                repeat (LAT + 3) begin
                    @(negedge clock);
                    check("abort_no_ready", 64'(bus.ready), 64'(0));
                end
                return;
            end
            if (bus.ready) begin
                got = 1'b1;
                break;
            end
            if (stall_len > 0 && n == stall_at) bus.enable = 1'b0;
            if (stall_len > 0 && n == stall_at + stall_len) bus.enable = 1'b1;
            @(negedge clock);
            n++;
        end
        bus.enable = 1'b1;
        check("latency", 64'(n), 64'(LAT + 1 + stall_len));
        exp = exp_q.pop_front();
        if (got) begin
            if (rd_known) check("resp_data_err", 64'({bus.error, bus.rData}), 64'(exp));
            else          check("resp_err", 64'(bus.error), 64'(exp[DW]));
        end
        if (wr && !mis) begin
            model[idx] = (model[idx] & ~mask) | (data & mask);
            known[idx] = known[idx] | (mask == '1);
        end
        @(negedge clock);
        check("ready_one_cycle", 64'(bus.ready), 64'(0));
        check("idle_outputs", 64'({bus.busy, bus.error, bus.rData}), 64'(0));
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.request    = 1'b0;
        bus.write      = 1'b0;
        bus.dataAddr   = '0;
        bus.wData      = '0;
        bus.wDataMask  = '0;
        bus0.enable    = 1'b1;
        bus0.request   = 1'b0;
        bus0.write     = 1'b0;
        bus0.dataAddr  = '0;
        bus0.wData     = '0;
        bus0.wDataMask = '0;
        for (int i = 0; i < WORDS; i++) known[i] = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 64'({bus.ready, bus.busy, bus.error, bus.rData}), 64'(0));
        check("reset_state", 64'(bus.dbg_state), 64'(IDLE));
        check("reset_outputs0", 64'({bus0.ready, bus0.busy, bus0.error}), 64'(0));
        reset = 1'b0;

        // full-word store, load back, half-word and byte merges, empty mask
        access(1'b1, 12'h010, 32'hDEAD_BEEF, MASK_WORD, 0, 0, 0);
        access(1'b0, 12'h010, 32'h0,         MASK_WORD, 0, 0, 0);
        access(1'b1, 12'h010, 32'h0000_1234, MASK_HALF, 0, 0, 0);
        access(1'b0, 12'h010, 32'h0,         MASK_WORD, 0, 0, 0);
        access(1'b1, 12'h014, 32'h0102_0304, MASK_WORD, 0, 0, 0);
        access(1'b1, 12'h014, 32'hAABB_CCDD, MASK_BYTE, 0, 0, 0);
        access(1'b0, 12'h014, 32'h0,         MASK_WORD, 0, 0, 0);
        access(1'b1, 12'h014, 32'hFFFF_FFFF, 32'h0,     0, 0, 0);
        access(1'b0, 12'h014, 32'h0,         MASK_WORD, 0, 0, 0);

        // top word of the address space
        access(1'b1, 12'hFFC, 32'h1357_9BDF, MASK_WORD, 0, 0, 0);
        access(1'b0, 12'hFFC, 32'h0,         MASK_WORD, 0, 0, 0);

        // reset during WAIT of a store aborts it
        access(1'b1, 12'h020, 32'h1111_1111, MASK_WORD, 0, 0, 0);
        access(1'b1, 12'h020, 32'h2222_2222, MASK_WORD, 0, 0, 1);
        access(1'b0, 12'h020, 32'h0,         MASK_WORD, 0, 0, 0);

        // enable low for three cycles in WAIT
        access(1'b0, 12'h010, 32'h0,         MASK_WORD, 1, 3, 0);

        // misaligned full-word and half-word stores
        access(1'b1, 12'h012, 32'hCAFE_F00D, MASK_WORD, 0, 0, 0);
        access(1'b0, 12'h010, 32'h0,         MASK_WORD, 0, 0, 0);
        access(1'b1, 12'h015, 32'h0000_5A5A, MASK_HALF, 0, 0, 0);
        access(1'b0, 12'h014, 32'h0,         MASK_WORD, 0, 0, 0);

        // random full-word stores with read-back
        for (int i = 0; i < 6; i++) begin
            a = AW'($urandom_range(16, 23)) << 2;
            d = $urandom();
            access(1'b1, a, d,    MASK_WORD, 0, 0, 0);
            access(1'b0, a, 32'h0, MASK_WORD, 0, 0, 0);
        end

        // Latency=0: back-to-back requests, the one during RESP is dropped
        @(negedge clock);
        bus0.request = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("lat0_ready_t1", 64'(bus0.ready), 64'(1));
        @(posedge clock);
        @(negedge clock);
        check("lat0_ignored_t2", 64'({bus0.ready, bus0.busy}), 64'(0));
        @(posedge clock);
        @(negedge clock);
        check("lat0_ready_t3", 64'(bus0.ready), 64'(1));
        bus0.request = 1'b0;
        @(negedge clock);
        check("lat0_idle", 64'({bus0.ready, bus0.busy}), 64'(0));

        check("queue_drained", 64'(exp_q.size()), 64'(0));

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 32, data word width in bits.
REQ-002 SHALL have parameter AddrWidth, default 12, byte-address width, giving 2^(AddrWidth-2) words.
REQ-003 SHALL have parameter Latency, default 2, wait cycles between accept and response, legal range 0..15.
REQ-004 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1; when low, state, counter and memory are frozen.
REQ-007 SHALL have port request, input, 1, initiator access strobe.
REQ-008 SHALL have port write, input, 1; 1 = store, 0 = load.
REQ-009 SHALL have port dataAddr, input, AddrWidth, byte address.
REQ-010 SHALL have port wData, input, DataWidth, store data.
REQ-011 SHALL have port wDataMask, input, DataWidth, per-bit write mask.
REQ-012 SHALL have port ready, output, 1, one-cycle response strobe.
REQ-013 SHALL have port rData, output, DataWidth, read data, valid while ready=1.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port error, output, 1, misalignment flag, valid while ready=1.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 In IDLE, request=1 with enable=1 SHALL accept: latch write, word index dataAddr[AddrWidth-1:2], dataAddr[1:0], wData and wDataMask.
REQ-018 On accept, the FSM SHALL go to RESP if Latency=0, otherwise to WAIT with the counter loaded to Latency-1.
REQ-019 In WAIT, the counter SHALL decrement each enabled cycle and move to RESP on the cycle it reads 0.
REQ-020 For an accept in cycle T with enable held high, ready SHALL be 1 in cycle T+Latency+1 only.
REQ-021 On entry to RESP, rData SHALL capture the addressed word's contents from before any write of this access.
REQ-022 A store SHALL commit mem[word] = (old & ~mask) | (wData & mask) at the edge ending RESP.
REQ-023 A store with wDataMask=0 SHALL leave memory unchanged and still respond.
REQ-024 RESP SHALL always return to IDLE; request during WAIT or RESP SHALL be ignored, not queued.
REQ-025 Maximum throughput SHALL be one access per Latency+2 cycles.
REQ-026 Address bits above AddrWidth SHALL not exist; the word index wraps modulo depth.
REQ-027 ready, rData and error SHALL be 0 outside RESP.

Reset
REQ-028 reset=1 SHALL force IDLE, counter 0, ready 0, rData 0, busy 0 and error 0 on the next edge, regardless of enable.
REQ-029 A reset asserted during WAIT or RESP SHALL abort the access with no memory write and no ready.
REQ-030 reset SHALL NOT clear memory contents.

Configuration
REQ-031 Macro DATA_MEM_ALIGN_CHECK_EN SHALL compile the alignment check in or out.
REQ-032 Macro defined: an access is misaligned if mask is full word and addr[1:0]!=0, or mask is the low half-word and addr[0]=1.
REQ-033 Macro defined, misaligned access: error=1 with ready, store suppressed, rData=0.
REQ-034 Macro undefined: error SHALL be tied 0 and addr[1:0] ignored.

Structure
REQ-035 DataWidth default, state enum (IDLE/WAIT/RESP) and mask constants (word, half-word, byte) SHALL live in the shared Parameter/Enum packages.
REQ-036 The storage array SHALL be one sub-module, data_mem_array: one synchronous read port and one masked write port.

Verification
REQ-037 Latency=2: store 0xDEADBEEF to 0x010 with full mask at T -> ready at T+3; a later load of 0x010 returns 0xDEADBEEF.
REQ-038 Word 0x010 = 0xDEADBEEF; store 0x00001234 with mask 0x0000FFFF -> subsequent load returns 0xDEAD1234.
REQ-039 Latency=0: request at T -> ready at T+1; a request at T+1 is ignored; a request at T+2 is accepted.
REQ-040 reset asserted in WAIT of a store -> ready never asserts; load of that address returns the old value; busy=0 next cycle.
REQ-041 enable low for 3 cycles during WAIT -> ready delayed by exactly 3 cycles.
REQ-042 Macro defined: full-mask store to 0x012 -> error=1 with ready, rData=0, memory unchanged. Macro undefined: same access writes word 0x010.
